// File: rtl/axi_rd_data_buf_pkg.sv
// Shared AXI4 R-channel types for the read data buffer.
// Optional macro AXI_R_USER_EN adds the per-beat user field.
package axi_rd_pkg;

  localparam int unsigned AXI_ID_W   = 16;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_USER_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    axi_resp_e             resp;
    logic                  last;
`ifdef AXI_R_USER_EN
    logic [AXI_USER_W-1:0] user;
`endif
  } r_beat_t;

  // SLVERR and DECERR both carry resp[1]=1.
  function automatic logic is_err(axi_resp_e resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_rd_data_buf_if.sv
// AXI4 R-channel bundle; master drives the beat, slave drives rready.
// Optional macro AXI_R_USER_EN adds the ruser signal.
interface axi_rd_data_buf_if #(
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32
`ifdef AXI_R_USER_EN
  , parameter int USER_WIDTH = 4
`endif
);

  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
`ifdef AXI_R_USER_EN
  logic [USER_WIDTH-1:0] ruser;
`endif

  modport master (
    output rvalid, rid, rdata, rresp, rlast,
`ifdef AXI_R_USER_EN
    output ruser,
`endif
    input  rready
  );

  modport slave (
    input  rvalid, rid, rdata, rresp, rlast,
`ifdef AXI_R_USER_EN
    input  ruser,
`endif
    output rready
  );

endinterface

// File: rtl/axi_rd_fifo_mem.sv
// Beat storage for the R-channel buffer: synchronous write, asynchronous read.
// Storage is deliberately not reset; validity is tracked by the pointers.
module axi_rd_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_rd_data_buf.sv
// Elastic AXI4 R-channel buffer with beat counting, burst-done pulse and sticky error.
// Optional macro AXI_R_USER_EN carries ruser through the buffer.
module axi_rd_data_buf
  import axi_rd_pkg::*;
#(
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int ID_WIDTH   = AXI_ID_W,
  parameter int DEPTH      = 4,
  parameter int BEAT_CNT_W = 8,
  parameter int USER_WIDTH = AXI_USER_W
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi_rd_data_buf_if.slave         s_r,
  axi_rd_data_buf_if.master        m_r,
  output logic [$clog2(DEPTH):0]   level,
  output logic [BEAT_CNT_W-1:0]    beat_cnt,
  output logic                     burst_done,
  output logic                     resp_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (DATA_WIDTH % 8) != 0 ||
      USER_WIDTH < 1) begin : g_param_err
    $error("axi_rd_data_buf: illegal parameter combination");
  end

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    axi_resp_e             resp;
    logic                  last;
`ifdef AXI_R_USER_EN
    logic [USER_WIDTH-1:0] user;
`endif
  } beat_t;

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  init_q, init_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  burst_done_q, burst_done_d;
  logic                  resp_err_q, resp_err_d;

  logic [AW:0]           level_w;
  logic                  s_ready_w;
  logic                  push;
  logic                  pop;
  beat_t                 wr_beat;
  beat_t                 rd_beat;
  logic [$bits(beat_t)-1:0] rd_bits;

  // The wrap bit makes the pointer difference distinguish full from empty.
  assign level_w   = wr_ptr_q - rd_ptr_q;
  assign s_ready_w = init_q && (level_w != FULL_LVL);
  assign push      = s_r.rvalid && s_ready_w;
  assign pop       = m_r.rvalid && m_r.rready;

  always_comb begin
    wr_beat      = '0;
    wr_beat.id   = s_r.rid;
    wr_beat.data = s_r.rdata;
    wr_beat.resp = axi_resp_e'(s_r.rresp);
    wr_beat.last = s_r.rlast;
`ifdef AXI_R_USER_EN
    wr_beat.user = s_r.ruser;
`endif
  end

  axi_rd_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_mem (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_bits)
  );

  assign rd_beat    = beat_t'(rd_bits);
  assign s_r.rready = s_ready_w;
  assign m_r.rvalid = (level_w != '0);
  assign m_r.rid    = rd_beat.id;
  assign m_r.rdata  = rd_beat.data;
  assign m_r.rresp  = rd_beat.resp;
  assign m_r.rlast  = rd_beat.last;
`ifdef AXI_R_USER_EN
  assign m_r.ruser  = rd_beat.user;
`endif

  always_comb begin
    init_d       = 1'b1;
    wr_ptr_d     = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW + 1)'(pop);
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = pop && rd_beat.last;
    if (pop) begin
      if (rd_beat.last) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    // Set has priority over a simultaneous clear.
    resp_err_d = (pop && is_err(rd_beat.resp)) || (resp_err_q && !err_clr);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      init_q       <= init_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign level      = level_w;
  assign beat_cnt   = beat_cnt_q;
  assign burst_done = burst_done_q;
  assign resp_err   = resp_err_q;

endmodule
